prio_age_grant_ctrl: RTL and testbench

- Sequential controller wrapped around the 8-input lowest-value priority arbiter.
- Upstream role: holds eight per-requester priority counters and drives them, masked by request, onto the arbiter's in7..in0.
- Downstream role: consumes the arbiter's 3-bit winner index, issues a one-hot held grant, and ages losing requesters so none starve.

---
 rtl/prio_age_grant_ctrl_if.sv | 26 ++
 rtl/prio_age_grant_ctrl.sv | 127 ++++++++++++
 tb/tb_prio_age_grant_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prio_age_grant_ctrl_if.sv
// Request/grant bundle between the aging grant controller and its
// surroundings (requesters, external lowest-value arbiter).
interface prio_age_grant_ctrl_if #(
    parameter int N      = 8,
    parameter int HOLD_W = 4
);
    logic [7:0]        req;
    logic [8*N-1:0]    base_prio;
    logic              load;
    logic [HOLD_W-1:0] max_hold;
    logic              done;
    logic [2:0]        win_idx;
    logic [N-1:0]      prio0, prio1, prio2, prio3, prio4, prio5, prio6, prio7;
    logic [7:0]        grant;
    logic              busy;

    modport master (
        output req, base_prio, load, max_hold, done, win_idx,
        input  prio0, prio1, prio2, prio3, prio4, prio5, prio6, prio7, grant, busy
    );

    modport slave (
        input  req, base_prio, load, max_hold, done, win_idx,
        output prio0, prio1, prio2, prio3, prio4, prio5, prio6, prio7, grant, busy
    );
endinterface

// File: rtl/prio_age_grant_ctrl.sv
// Aging grant controller: presents per-requester priority counters to an
// external lowest-value arbiter and issues a held one-hot grant to its winner.
//
// state     | meaning
// S_IDLE    | accept load, or start a grant to the arbiter's winner
// S_GRANT   | grant held until done, winner drops req, or hold timeout
// S_RELEASE | dead cycle so the arbiter sees the aged counters
module prio_age_grant_ctrl #(
    parameter int N      = 8,
    parameter int HOLD_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prio_age_grant_ctrl_if.slave  bus
);
    localparam logic [N-1:0] ALL1 = '1;
    localparam logic [N-1:0] MAXV = ALL1 - 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N-1:0]      r_base [8];
    logic [N-1:0]      r_cnt  [8];
    logic [7:0]        r_req_q;
    logic [7:0]        r_grant;
    logic [2:0]        r_win;
    logic [HOLD_W-1:0] r_hold;

    logic [N-1:0]      w_clamp [8];
    logic [N-1:0]      w_prio  [8];
    logic [HOLD_W-1:0] w_hold_lim;
    logic              w_end;
    logic              w_do_load;
    logic              w_do_start;
    logic              w_do_end;

    // All-ones is reserved for idle lines, so loaded values are capped below it.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_clamp[k] = (bus.base_prio[k*N +: N] == ALL1) ? MAXV : bus.base_prio[k*N +: N];
            w_prio[k]  = r_req_q[k] ? r_cnt[k] : ALL1;
        end
    end

    assign w_hold_lim = (bus.max_hold == '0) ? HOLD_W'(1) : bus.max_hold;
    assign w_end      = bus.done | ~r_req_q[r_win] | (r_hold == w_hold_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_do_load   = 1'b0;
        w_do_start  = 1'b0;
        w_do_end    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.load) begin
                    w_do_load = 1'b1;
                end else if (|r_req_q && r_req_q[bus.win_idx]) begin
                    w_do_start  = 1'b1;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_end) begin
                    w_do_end    = 1'b1;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                r_base[k] <= MAXV;
                r_cnt[k]  <= MAXV;
            end
            r_req_q <= '0;
            r_grant <= '0;
            r_win   <= '0;
            r_hold  <= '0;
        end else begin
            r_req_q <= bus.req;
            if (w_do_load) begin
                for (int k = 0; k < 8; k++) begin
                    r_base[k] <= w_clamp[k];
                    r_cnt[k]  <= w_clamp[k];
                end
            end
            if (w_do_start) begin
                r_win   <= bus.win_idx;
                r_grant <= 8'b1 << bus.win_idx;
                r_hold  <= HOLD_W'(1);
            end else if (w_do_end) begin
                r_grant <= '0;
                r_hold  <= '0;
                // Winner restarts from its base; waiting losers creep toward 0.
                for (int k = 0; k < 8; k++) begin
                    if (3'(k) == r_win)
                        r_cnt[k] <= r_base[k];
                    else if (r_req_q[k] && r_cnt[k] != '0)
                        r_cnt[k] <= r_cnt[k] - 1'b1;
                end
            end else if (r_state == S_GRANT) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign bus.prio0 = w_prio[0];
    assign bus.prio1 = w_prio[1];
    assign bus.prio2 = w_prio[2];
    assign bus.prio3 = w_prio[3];
    assign bus.prio4 = w_prio[4];
    assign bus.prio5 = w_prio[5];
    assign bus.prio6 = w_prio[6];
    assign bus.prio7 = w_prio[7];
    assign bus.grant = r_grant;
    assign bus.busy  = (r_state != S_IDLE);
endmodule

// File: tb/tb_prio_age_grant_ctrl.sv
// Scoreboard bench for prio_age_grant_ctrl: a golden lowest-value arbiter closes
// the loop, an abstract aging model predicts every grant, a monitor checks them.
module tb_prio_age_grant_ctrl;
    localparam int N  = 8;
    localparam int HW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prio_age_grant_ctrl_if #(.N(N), .HOLD_W(HW)) bus ();
    prio_age_grant_ctrl #(.N(N), .HOLD_W(HW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [N-1:0] pv [8];
    assign pv[0] = bus.prio0;
    assign pv[1] = bus.prio1;
    assign pv[2] = bus.prio2;
    assign pv[3] = bus.prio3;
    assign pv[4] = bus.prio4;
    assign pv[5] = bus.prio5;
    assign pv[6] = bus.prio6;
    assign pv[7] = bus.prio7;

    // Golden arbiter: lowest value wins, ties go to the lowest index.
    always_comb begin
        logic [2:0] b;
        b = 3'd0;
        for (int k = 1; k < 8; k++) if (pv[k] < pv[b]) b = 3'(k);
        bus.win_idx = b;
    end

    typedef struct {
        logic [7:0]  g;
        int          len;
        logic [63:0] snap;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   ngr = 0;
    int   cur_da = 99;
    int   mbase [8];
    int   mcnt  [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    function automatic logic [63:0] dut_snap();
        return {pv[7], pv[6], pv[5], pv[4], pv[3], pv[2], pv[1], pv[0]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            mbase[k] = 254;
            mcnt[k]  = 254;
        end
    endtask

    task automatic model_load(input logic [63:0] b);
        int v;
        for (int k = 0; k < 8; k++) begin
            v = int'(b[k*8 +: 8]);
            if (v == 255) v = 254;
            mbase[k] = v;
            mcnt[k]  = v;
        end
    endtask

    // One arbitration round: pick the winner, decide how long it holds, age the rest.
    task automatic model_grant(input logic [7:0] r, input int mh, input int da, input int drop_c,
                               output int w, output int len, output logic [63:0] snap);
        logic [7:0] mask;
        w = -1;
        for (int k = 0; k < 8; k++)
            if (r[k] && (w < 0 || mcnt[k] < mcnt[w])) w = k;
        len = (mh == 0) ? 1 : mh;
        if (da < len) len = da;
        mask = r;
        if (drop_c > 0) begin
            if (drop_c + 1 < len) len = drop_c + 1;
            mask = r & ~(8'b1 << w);
        end
        for (int k = 0; k < 8; k++) begin
            if (k == w) mcnt[k] = mbase[k];
            else if (mask[k] && mcnt[k] > 0) mcnt[k] = mcnt[k] - 1;
        end
        for (int k = 0; k < 8; k++) snap[k*8 +: 8] = mask[k] ? 8'(mcnt[k]) : 8'hFF;
    endtask

    logic       in_g = 1'b0;
    logic       gchg;
    logic [7:0] gval;
    int         glen;
    exp_t       e;

    // Monitor: measures each grant and checks it against the scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_g     = 1'b0;
            glen     = 0;
            bus.done = 1'b0;
        end else if (bus.grant != 8'h00) begin
            if (!in_g) begin
                in_g = 1'b1;
                gval = bus.grant;
                glen = 0;
                gchg = 1'b0;
            end
            if (bus.grant != gval) gchg = 1'b1;
            glen++;
            bus.done = (glen == cur_da);
        end else begin
            bus.done = 1'b0;
            if (in_g) begin
                in_g = 1'b0;
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_grant: got %0h expected none", gval);
                end else begin
                    e = q.pop_front();
                    chk("grant_idx", 64'(gval), 64'(e.g));
                    chk("grant_len", 64'(glen), 64'(e.len));
                    chk("grant_stable", 64'(gchg), 64'd0);
                    chk("prio_after_aging", dut_snap(), e.snap);
                end
                ngr++;
            end
        end
    end

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (bus.busy && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic round(input bit do_ld, input logic [63:0] base, input logic [7:0] r,
                         input int mh, input int da, input int k, input bit glitch, input int drop_c);
        int          w, len, tgt, cyc;
        logic [63:0] snap;
        logic [7:0]  first;
        exp_t        x;
        wait_idle();
        if (do_ld) begin
            bus.base_prio = base;
            bus.load      = 1'b1;
            @(negedge clk);
            #1;
            bus.load = 1'b0;
            model_load(base);
        end
        bus.max_hold = HW'(mh);
        cur_da       = da;
        first        = 8'h00;
        for (int i = 0; i < k; i++) begin
            model_grant(r, mh, da, drop_c, w, len, snap);
            if (i == 0) first = 8'b1 << w;
            x.g    = 8'b1 << w;
            x.len  = len;
            x.snap = snap;
            q.push_back(x);
        end
        tgt     = ngr + k;
        bus.req = r;
        @(negedge clk);
        chk("latency_idle", 64'(bus.grant), 64'd0);
        @(negedge clk);
        chk("latency_grant", 64'(bus.grant), 64'(first));
        if (glitch) begin
            #1;
            bus.base_prio = '0;
            bus.load      = 1'b1;
            @(negedge clk);
            #1;
            bus.load = 1'b0;
        end
        if (drop_c > 0) begin
            repeat (drop_c - 1) @(negedge clk);
            #1;
            bus.req = r & ~first;
        end
        cyc = 0;
        while (ngr < tgt && cyc < 400) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("round_complete", 64'(ngr), 64'(tgt));
        bus.req = 8'h00;
        if (ngr < tgt) q.delete();
    endtask

    task automatic rand_base(output logic [63:0] b);
        for (int k = 0; k < 8; k++) begin
            case ($urandom % 4)
                0:       b[k*8 +: 8] = 8'hFF;
                1:       b[k*8 +: 8] = 8'($urandom_range(0, 3));
                default: b[k*8 +: 8] = 8'($urandom % 256);
            endcase
        end
    endtask

    initial begin
        logic [63:0] b;
        int          cyc;
        bus.req       = 8'h00;
        bus.load      = 1'b0;
        bus.base_prio = '0;
        bus.max_hold  = '0;
        model_reset();

        repeat (2) @(negedge clk);
        chk("reset_grant", 64'(bus.grant), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_prio", dut_snap(), {8{8'hFF}});
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("idle_grant", 64'(bus.grant), 64'd0);
        chk("idle_busy", 64'(bus.busy), 64'd0);
        chk("idle_prio", dut_snap(), {8{8'hFF}});

        round(1'b1, {8{8'h10}}, 8'h08, 4, 16, 3, 1'b0, 0);
        round(1'b1, {{6{8'h40}}, 8'h20, 8'h05}, 8'h03, 15, 1, 30, 1'b0, 0);
        round(1'b1, {8{8'h30}}, 8'h06, 15, 16, 1, 1'b0, 2);
        round(1'b0, '0, 8'h06, 2, 16, 2, 1'b0, 0);
        round(1'b0, '0, 8'h0F, 3, 3, 2, 1'b0, 0);
        round(1'b0, '0, 8'h0F, 0, 16, 2, 1'b0, 0);
        round(1'b1, {{6{8'h80}}, 8'h00, 8'h00}, 8'h03, 2, 1, 3, 1'b0, 0);
        round(1'b1, {8{8'hFF}}, 8'hFF, 1, 16, 2, 1'b0, 0);
        round(1'b1, {8{8'h50}}, 8'h11, 5, 16, 2, 1'b1, 0);
        round(1'b0, '0, 8'h11, 2, 2, 2, 1'b0, 0);

        // Reset in the middle of a grant must drop it asynchronously.
        wait_idle();
        bus.max_hold = 4'd15;
        cur_da       = 16;
        bus.req      = 8'h0F;
        cyc          = 0;
        while (bus.grant == 8'h00 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("pre_reset_grant_seen", 64'(bus.grant != 8'h00), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midgrant_reset_grant", 64'(bus.grant), 64'd0);
        chk("midgrant_reset_busy", 64'(bus.busy), 64'd0);
        chk("midgrant_reset_prio", dut_snap(), {8{8'hFF}});
        bus.req = 8'h00;
        @(negedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        round(1'b0, '0, 8'hFF, 2, 16, 2, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            rand_base(b);
            round(1'($urandom % 2), b, 8'($urandom_range(1, 255)), $urandom_range(0, 15),
                  $urandom_range(1, 16), $urandom_range(1, 4), ($urandom % 4) == 0, 0);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
